// File: rtl/nexys_starship_pkg.sv
// Nexys Starship multi-station controller: shared types and constants.
// Top FSM encodings, game-over cause codes and timer width.
package nexys_starship_pkg;

  typedef enum logic [2:0] {
    INIT = 3'b001,
    PLAY = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_EXT     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_STRIKE  = 2'b11;

  localparam int TMR_W = 8;

endpackage

// File: rtl/nexys_starship_station.sv
// One damageable station: broken flag, latched repair combo and
// a saturating repair-deadline timer.
module nexys_starship_station
  import nexys_starship_pkg::*;
#(
  parameter int HEX_W         = 4,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en_play,
  input  logic             brk,
  input  logic             repair_hit,
  input  logic             tick,
  input  logic [HEX_W-1:0] random_hex,
  output logic             broken,
  output logic [HEX_W-1:0] combo,
  output logic             expired
);

  localparam logic [TMR_W-1:0] TMAX = TMR_W'(TIMEOUT_TICKS);

  logic [TMR_W-1:0] timer;

  // Repair has priority over a same-cycle break request.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      broken <= 1'b0;
      combo  <= '0;
      timer  <= '0;
    end else if (en_play) begin
      if (repair_hit) begin
        broken <= 1'b0;
        combo  <= '0;
        timer  <= '0;
      end else if (!broken && brk) begin
        broken <= 1'b1;
        combo  <= random_hex;
      end else if (broken && tick && timer != TMAX) begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign expired = (timer == TMAX);

endmodule

// File: rtl/nexys_starship_stations.sv
// Multi-station damage/repair controller: top FSM, keypad compare,
// strike/score counters and game-over cause priority.
module nexys_starship_stations
  import nexys_starship_pkg::*;
#(
  parameter int NUM_ST        = 4,
  parameter int HEX_W         = 4,
  parameter int SEL_W         = 2,
  parameter int TIMEOUT_TICKS = 20,
  parameter int MAX_WRONG     = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    play_flag,
  input  logic                    gameover_ctrl,
  input  logic [NUM_ST-1:0]       break_req,
  input  logic [HEX_W-1:0]        random_hex,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    submit,
  input  logic [HEX_W-1:0]        hex_combo,
  input  logic                    tick,
  output logic                    q_Init,
  output logic                    q_Play,
  output logic                    q_Done,
  output logic [NUM_ST-1:0]       broken,
  output logic [NUM_ST*HEX_W-1:0] combos,
  output logic                    repaired,
  output logic [3:0]              wrong_cnt,
  output logic [7:0]              score,
  output logic [1:0]              over_cause
);

  state_t           state;
  logic             clr;
  logic             en_play;
  logic             sel_broken;
  logic [HEX_W-1:0] sel_combo;
  logic             hit;
  logic             miss;
  logic [NUM_ST-1:0] expired;
  logic [HEX_W-1:0] st_combo [NUM_ST];

  assign en_play = (state == PLAY);
  // Clear on the edge that enters INIT as well as while in INIT.
  assign clr = (state == INIT) || (state == DONE && play_flag);

  always_comb begin
    sel_broken = 1'b0;
    sel_combo  = '0;
    for (int i = 0; i < NUM_ST; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_broken = broken[i];
        sel_combo  = st_combo[i];
      end
    end
  end

  assign hit  = en_play && submit && sel_broken &&
                (hex_combo == sel_combo);
  assign miss = en_play && submit && sel_broken &&
                (hex_combo != sel_combo);

  for (genvar g = 0; g < NUM_ST; g++) begin : g_st
    nexys_starship_station #(
      .HEX_W        (HEX_W),
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_st (
      .Clk       (Clk),
      .Reset     (Reset),
      .clr       (clr),
      .en_play   (en_play),
      .brk       (break_req[g]),
      .repair_hit(hit && (sel == SEL_W'(g))),
      .tick      (tick),
      .random_hex(random_hex),
      .broken    (broken[g]),
      .combo     (st_combo[g]),
      .expired   (expired[g])
    );
    assign combos[g*HEX_W +: HEX_W] = st_combo[g];
  end

  assign q_Init = (state == INIT);
  assign q_Play = (state == PLAY);
  assign q_Done = (state == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= INIT;
      wrong_cnt  <= '0;
      score      <= '0;
      repaired   <= 1'b0;
      over_cause <= CAUSE_NONE;
    end else begin
      repaired <= 1'b0;
      unique case (state)
        INIT: begin
          wrong_cnt  <= '0;
          score      <= '0;
          over_cause <= CAUSE_NONE;
          if (play_flag) state <= PLAY;
        end
        PLAY: begin
          repaired <= hit;
          if (hit && score != 8'hFF) score <= score + 1'b1;
          if (miss && wrong_cnt != 4'hF) wrong_cnt <= wrong_cnt + 1'b1;
          if (gameover_ctrl) begin
            state      <= DONE;
            over_cause <= CAUSE_EXT;
          end else if (|expired) begin
            state      <= DONE;
            over_cause <= CAUSE_TIMEOUT;
          end else if (wrong_cnt == 4'(MAX_WRONG)) begin
            state      <= DONE;
            over_cause <= CAUSE_STRIKE;
          end
        end
        DONE: begin
          if (play_flag) begin
            state      <= INIT;
            wrong_cnt  <= '0;
            score      <= '0;
            over_cause <= CAUSE_NONE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/nexys_starship_stations.md
Name: nexys_starship_stations

Overview:
- Parametrised multi-station damage/repair controller for Nexys Starship; generalises the single left-room repair FSM to NUM_ST rooms sharing one hex keypad.
- Each station breaks on a random request, latches a repair combo, and is repaired by a matching combo submitted while it is selected.
- Adds features the single-room block lacks: per-station repair deadline, wrong-entry strike limit, repair scoring and a game-over cause code.
- Sits between the random-event generator and keypad/debouncer on one side, and the VGA/score display and top game FSM on the other.

Parameters:
- NUM_ST, 4, number of stations (2..8)
- HEX_W, 4, combo width in bits
- SEL_W, 2, station-select width; must satisfy 2**SEL_W >= NUM_ST
- TIMEOUT_TICKS, 20, tick count a station may remain broken before game over (1..255)
- MAX_WRONG, 3, wrong submissions that end the game (1..15)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clk
- play_flag  in  1  start pulse; also acknowledges DONE
- gameover_ctrl  in  1  external game-over request
- break_req  in  NUM_ST  per-station break request pulses
- random_hex  in  HEX_W  random combo source
- sel  in  SEL_W  currently selected station
- submit  in  1  single-cycle debounced enter pulse
- hex_combo  in  HEX_W  player keypad value
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz)
- q_Init, q_Play, q_Done  out  1 each  one-hot top state
- broken  out  NUM_ST  station broken flags
- combos  out  NUM_ST*HEX_W  latched combos, station i at bits [i*HEX_W +: HEX_W]
- repaired  out  1  one-cycle pulse on a successful repair
- wrong_cnt  out  4  wrong submissions, saturating
- score  out  8  successful repairs, saturating at 255
- over_cause  out  2  00 none, 01 external, 10 timeout, 11 strikes

Behaviour:
- Reset, and every cycle in INIT: state=INIT; broken=0; combos=0; timers=0; wrong_cnt=0; score=0; repaired=0; over_cause=00.
- Top FSM:
  - INIT -> PLAY on play_flag.
  - PLAY -> DONE on the first of: gameover_ctrl (cause 01); any station timer == TIMEOUT_TICKS (10); wrong_cnt == MAX_WRONG (11). Simultaneous causes resolve by priority 01 > 10 > 11.
  - DONE -> INIT on play_flag. DONE freezes broken, combos, score, wrong_cnt and over_cause for display.
- Station i, PLAY only:
  - If !broken[i] and break_req[i]: broken[i]=1 and combo[i]=random_hex on the next edge (1-cycle latency).
  - break_req to an already-broken station is ignored; combo is not overwritten.
  - Simultaneous breaks on several stations all latch the same random_hex.
- Repair (PLAY only): submit && sel<NUM_ST && broken[sel]:
  - Match (hex_combo == combo[sel]): next edge clears broken[sel], combo[sel] and timer[sel]; repaired=1 for one cycle; score+1, saturating.
  - Mismatch: wrong_cnt+1, saturating at 15.
  - submit with a non-broken or out-of-range sel is ignored and counts no strike.
- Same-cycle repair and break_req on the same station: the repair wins; the station ends unbroken and the request is dropped.
- Timer:
  - Per-station 8-bit timer increments on tick while broken[i]; holds at TIMEOUT_TICKS; clears on repair.
  - The game-over transition occurs on the edge after the timer reaches TIMEOUT_TICKS.
- Reset mid-PLAY returns to INIT within one cycle; no output retains its pre-reset value.
- Inputs other than play_flag are ignored outside PLAY.

Decomposition:
- Package nexys_starship_pkg holds:
  - top state encodings INIT=3'b001, PLAY=3'b010, DONE=3'b100
  - over_cause codes CAUSE_NONE, CAUSE_EXT, CAUSE_TIMEOUT, CAUSE_STRIKE
  - timer width constant TMR_W=8
- Sub-module nexys_starship_station, one instance per station: broken flag, combo register, timer.
  - Inputs: clr, en_play, break, repair_hit, tick.
  - Outputs: broken, combo, expired.
- The top level holds the FSM, select/compare mux, strike and score counters, and cause priority.

Test Plan:
- Reset, play_flag, break_req=4'b0010 with random_hex=4'hA -> next cycle broken=4'b0010 and combos[7:4]=4'hA; submit sel=1 hex_combo=4'hA -> broken=0, repaired pulse, score=1.
- Station 1 broken with combo 4'h5; submit sel=1 hex_combo=4'h3 three times (MAX_WRONG=3) -> wrong_cnt=3, then q_Done=1, over_cause=11, broken still 4'b0010.
- Break station 0; apply 20 tick pulses -> DONE on the following edge, over_cause=10; a further submit changes nothing.
- Station 2 broken; in one cycle assert a correct submit sel=2 together with break_req[2] and random_hex=4'hF -> broken[2]=0 and combo[2]=0.
- Same cycle: gameover_ctrl and station timer expiry -> over_cause=01; then play_flag -> INIT with all outputs cleared.
- Assert Reset mid-PLAY with two stations broken and score=5 -> next edge q_Init=1, broken=0, score=0, wrong_cnt=0.
